// File: rtl/tlb_maint_pkg.sv
// tlb_maint: shared entry layout and op encodings.
// Imported by the maintenance unit and its consumers.
package tlb_maint_pkg;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  localparam logic [1:0] OP_TLBR  = 2'b00;
  localparam logic [1:0] OP_TLBWI = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b10;
  localparam logic [1:0] OP_TLBP  = 2'b11;

endpackage

// File: rtl/tlb_maint_if.sv
// tlb_maint: CP0 request / response bundle.
// master = CP0 stage, slave = TLB maintenance unit.
interface tlb_maint_if;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  cp0_index;
  logic [31:0] cp0_entryhi;
  logic [31:0] cp0_entrylo0;
  logic [31:0] cp0_entrylo1;

  logic        resp_valid;
  logic [1:0]  resp_op;
  logic [31:0] resp_index;
  logic [31:0] resp_entryhi;
  logic [31:0] resp_entrylo0;
  logic [31:0] resp_entrylo1;

  modport master (
    output req_valid, req_op, cp0_index,
    output cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
    input  req_ready, resp_valid, resp_op,
    input  resp_index, resp_entryhi,
    input  resp_entrylo0, resp_entrylo1
  );

  modport slave (
    input  req_valid, req_op, cp0_index,
    input  cp0_entryhi, cp0_entrylo0, cp0_entrylo1,
    output req_ready, resp_valid, resp_op,
    output resp_index, resp_entryhi,
    output resp_entrylo0, resp_entrylo1
  );

endinterface

// File: rtl/tlb_maint.sv
// tlb_maint: 16-entry JTLB storage, TLBR/TLBWI/TLBWR/TLBP
// execution and CP0 Random maintenance.
`ifndef TLB_ENTRIES_NUM
`define TLB_ENTRIES_NUM 16
`endif

module tlb_maint
  import tlb_maint_pkg::*;
#(
  parameter int TLB_NUM = `TLB_ENTRIES_NUM
) (
  input  logic       clk,
  input  logic       rst,
  tlb_maint_if.slave bus,
  input  logic       wired_we,
  input  logic [3:0] cp0_wired,
  output logic [3:0] random,
  output tlb_entry_t entries [TLB_NUM],
  output logic       tlb_changed
);

  typedef enum logic [1:0] {
    IDLE,
    PROBE1,
    PROBE2,
    RESP
  } state_t;

  state_t state, state_n;

  logic [18:0]        vpn2_q;
  logic [7:0]         asid_q;
  logic [TLB_NUM-1:0] match;
  logic [TLB_NUM-1:0] match_q;
  logic               hit;
  logic [3:0]         hit_idx;
  logic               accept;
  logic               do_write;
  logic               do_read;
  logic [3:0]         widx;
  logic [3:0]         random_n;
  tlb_entry_t         wentry;
  tlb_entry_t         rentry;
  logic               unused_bits;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign do_read  = accept && (bus.req_op == OP_TLBR);
  assign do_write = accept &&
                    ((bus.req_op == OP_TLBWI) ||
                     (bus.req_op == OP_TLBWR));
  assign widx     = (bus.req_op == OP_TLBWR) ?
                    random : bus.cp0_index;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);

  assign rentry = entries[bus.cp0_index];

  assign unused_bits = ^{bus.cp0_entryhi[12:8],
                         bus.cp0_entrylo0[31:26],
                         bus.cp0_entrylo1[31:26]};

  always_comb begin
    wentry      = '0;
    wentry.vpn2 = bus.cp0_entryhi[31:13];
    wentry.asid = bus.cp0_entryhi[7:0];
    wentry.g    = bus.cp0_entrylo0[0] &
                  bus.cp0_entrylo1[0];
    wentry.pfn0 = bus.cp0_entrylo0[25:6];
    wentry.c0   = bus.cp0_entrylo0[5:3];
    wentry.d0   = bus.cp0_entrylo0[2];
    wentry.v0   = bus.cp0_entrylo0[1];
    wentry.pfn1 = bus.cp0_entrylo1[25:6];
    wentry.c1   = bus.cp0_entrylo1[5:3];
    wentry.d1   = bus.cp0_entrylo1[2];
    wentry.v1   = bus.cp0_entrylo1[1];
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < TLB_NUM; i++) begin
      match[i] = (entries[i].vpn2 == vpn2_q) &&
                 (entries[i].g ||
                  (entries[i].asid == asid_q));
    end
  end

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = TLB_NUM - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  always_comb begin
    random_n = random - 4'd1;
    if (wired_we ||
        (random == cp0_wired) ||
        (random == 4'd0)) begin
      random_n = 4'd15;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_n = (bus.req_op == OP_TLBP) ?
                    PROBE1 : RESP;
        end
      end
      PROBE1:  state_n = PROBE2;
      PROBE2:  state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      random            <= 4'd15;
      tlb_changed       <= 1'b0;
      vpn2_q            <= '0;
      asid_q            <= '0;
      match_q           <= '0;
      bus.resp_op       <= '0;
      bus.resp_index    <= '0;
      bus.resp_entryhi  <= '0;
      bus.resp_entrylo0 <= '0;
      bus.resp_entrylo1 <= '0;
      for (int i = 0; i < TLB_NUM; i++) begin
        entries[i] <= '0;
      end
    end else begin
      state       <= state_n;
      random      <= random_n;
      tlb_changed <= do_write;
      if (accept) begin
        bus.resp_op <= bus.req_op;
        vpn2_q      <= bus.cp0_entryhi[31:13];
        asid_q      <= bus.cp0_entryhi[7:0];
      end
      if (do_write) begin
        entries[widx] <= wentry;
      end
      if (do_read) begin
        bus.resp_entryhi  <= {rentry.vpn2, 5'b0,
                              rentry.asid};
        bus.resp_entrylo0 <= {6'b0, rentry.pfn0,
                              rentry.c0, rentry.d0,
                              rentry.v0, rentry.g};
        bus.resp_entrylo1 <= {6'b0, rentry.pfn1,
                              rentry.c1, rentry.d1,
                              rentry.v1, rentry.g};
      end
      if (state == PROBE1) begin
        match_q <= match;
      end
      if (state == PROBE2) begin
        bus.resp_index <= hit ?
                          {28'b0, hit_idx} :
                          32'h8000_0000;
      end
    end
  end

endmodule
